// File: rtl/gpc_4t_c2f_req_arb.sv
// gpc_4t_c2f_req_arb
//   Arbitrates the four gpc_4t hardware threads onto the single core-to-fabric
//   (C2F) request port. Each thread has a one-entry request buffer. Pending
//   requests are granted round-robin onto registered C2F outputs, which hold
//   while the fabric stalls. The arbiter tracks one outstanding read per
//   thread and routes C2F responses back to the issuing thread by ThreadID.
//
// Ports
//   QClk, RstQnnnL                 clock, synchronous active-low reset
//   ThreadReq{Valid,Opcode,Address,Data}  per-thread request inputs
//   ThreadReqReady                 per-thread ready (thread is IDLE)
//   C2F_Req*Q500H                  registered request to the fabric
//   C2F_RspStall                   fabric back-pressure; request outputs hold
//   C2F_Rsp*Q502H                  response from the fabric
//   ThreadRspValid/ThreadRspData   registered one-hot response to the threads
//   ErrUnexpRsp, ErrIllegalOp      one-cycle error pulses
module gpc_4t_c2f_req_arb #(
  parameter int NUM_THREADS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                                QClk,
  input  logic                                RstQnnnL,
  input  logic [NUM_THREADS-1:0]              ThreadReqValid,
  input  logic [NUM_THREADS-1:0][1:0]         ThreadReqOpcode,
  input  logic [NUM_THREADS-1:0][ADDR_W-1:0]  ThreadReqAddress,
  input  logic [NUM_THREADS-1:0][DATA_W-1:0]  ThreadReqData,
  output logic [NUM_THREADS-1:0]              ThreadReqReady,
  output logic                                C2F_ReqValidQ500H,
  output logic [1:0]                          C2F_ReqOpcodeQ500H,
  output logic [1:0]                          C2F_ReqThreadIDQ500H,
  output logic [ADDR_W-1:0]                   C2F_ReqAddressQ500H,
  output logic [DATA_W-1:0]                   C2F_ReqDataQ500H,
  input  logic                                C2F_RspStall,
  input  logic                                C2F_RspValidQ502H,
  input  logic [1:0]                          C2F_RspThreadIDQ502H,
  input  logic [DATA_W-1:0]                   C2F_RspDataQ502H,
  output logic [NUM_THREADS-1:0]              ThreadRspValid,
  output logic [DATA_W-1:0]                   ThreadRspData,
  output logic                                ErrUnexpRsp,
  output logic                                ErrIllegalOp
);

  localparam int TID_W = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    WAIT_RSP = 2'd2
  } thr_st_e;

  thr_st_e           st_p0   [NUM_THREADS];
  logic [1:0]        op_p0   [NUM_THREADS];
  logic [ADDR_W-1:0] addr_p0 [NUM_THREADS];
  logic [DATA_W-1:0] data_p0 [NUM_THREADS];
  logic [TID_W-1:0]  rr_ptr;

  logic              slot_free;
  logic              gnt_vld;
  logic [TID_W-1:0]  gnt_id;
  logic              rsp_hit;

  // Opcodes 2'b10 and 2'b11 are illegal: forwarded as-is but never tracked.
  function automatic logic is_read(input logic [1:0] op);
    return (op == 2'b00);
  endfunction

  function automatic logic is_illegal(input logic [1:0] op);
    return op[1];
  endfunction

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      ThreadReqReady[t] = (st_p0[t] == IDLE);
    end
  end

  assign slot_free = !C2F_ReqValidQ500H || !C2F_RspStall;

  // Round-robin search starts one past the last granted thread.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_THREADS;
      if (!gnt_vld && slot_free && (st_p0[idx] == PEND)) begin
        gnt_vld = 1'b1;
        gnt_id  = TID_W'(idx);
      end
    end
  end

  assign rsp_hit = C2F_RspValidQ502H && (st_p0[C2F_RspThreadIDQ502H] == WAIT_RSP);

  // Stage p0: per-thread state and request buffers
  always_ff @(posedge QClk) begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (!RstQnnnL) begin
        st_p0[t] <= IDLE;
      end else begin
        case (st_p0[t])
          IDLE: begin
            if (ThreadReqValid[t]) st_p0[t] <= PEND;
          end
          PEND: begin
            if (gnt_vld && (gnt_id == TID_W'(t))) begin
              st_p0[t] <= is_read(op_p0[t]) ? WAIT_RSP : IDLE;
            end
          end
          WAIT_RSP: begin
            if (C2F_RspValidQ502H && (C2F_RspThreadIDQ502H == TID_W'(t))) st_p0[t] <= IDLE;
          end
          default: st_p0[t] <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge QClk) begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      if ((st_p0[t] == IDLE) && ThreadReqValid[t]) begin
        op_p0[t]   <= ThreadReqOpcode[t];
        addr_p0[t] <= ThreadReqAddress[t];
        data_p0[t] <= ThreadReqData[t];
      end
    end
  end

  // Stage p1: registered C2F request outputs
  always_ff @(posedge QClk) begin
    if (!RstQnnnL) begin
      rr_ptr               <= TID_W'(NUM_THREADS - 1);
      C2F_ReqValidQ500H    <= 1'b0;
      C2F_ReqOpcodeQ500H   <= '0;
      C2F_ReqThreadIDQ500H <= '0;
      C2F_ReqAddressQ500H  <= '0;
      C2F_ReqDataQ500H     <= '0;
      ErrIllegalOp         <= 1'b0;
    end else begin
      ErrIllegalOp <= 1'b0;
      if (gnt_vld) begin
        rr_ptr               <= gnt_id;
        C2F_ReqValidQ500H    <= 1'b1;
        C2F_ReqOpcodeQ500H   <= op_p0[gnt_id];
        C2F_ReqThreadIDQ500H <= gnt_id;
        C2F_ReqAddressQ500H  <= addr_p0[gnt_id];
        C2F_ReqDataQ500H     <= data_p0[gnt_id];
        ErrIllegalOp         <= is_illegal(op_p0[gnt_id]);
      end else if (slot_free) begin
        C2F_ReqValidQ500H <= 1'b0;
      end
    end
  end

  // Stage p1: registered response routing
  always_ff @(posedge QClk) begin
    if (!RstQnnnL) begin
      ThreadRspValid <= '0;
      ThreadRspData  <= '0;
      ErrUnexpRsp    <= 1'b0;
    end else begin
      ThreadRspValid <= '0;
      ErrUnexpRsp    <= C2F_RspValidQ502H && !rsp_hit;
      if (rsp_hit) begin
        ThreadRspValid[C2F_RspThreadIDQ502H] <= 1'b1;
        ThreadRspData                        <= C2F_RspDataQ502H;
      end
    end
  end

endmodule

// File: tb/tb_gpc_4t_c2f_req_arb.sv
// tb_gpc_4t_c2f_req_arb
//   Directed self-checking bench for gpc_4t_c2f_req_arb: read round trip,
//   round-robin write issue, stall hold, unexpected response, reset with a
//   read outstanding, and illegal opcode forwarding.
module tb_gpc_4t_c2f_req_arb;

  localparam int NT = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                      QClk = 1'b0;
  logic                      RstQnnnL;
  logic [NT-1:0]             ThreadReqValid;
  logic [NT-1:0][1:0]        ThreadReqOpcode;
  logic [NT-1:0][AW-1:0]     ThreadReqAddress;
  logic [NT-1:0][DW-1:0]     ThreadReqData;
  logic [NT-1:0]             ThreadReqReady;
  logic                      C2F_ReqValidQ500H;
  logic [1:0]                C2F_ReqOpcodeQ500H;
  logic [1:0]                C2F_ReqThreadIDQ500H;
  logic [AW-1:0]             C2F_ReqAddressQ500H;
  logic [DW-1:0]             C2F_ReqDataQ500H;
  logic                      C2F_RspStall;
  logic                      C2F_RspValidQ502H;
  logic [1:0]                C2F_RspThreadIDQ502H;
  logic [DW-1:0]             C2F_RspDataQ502H;
  logic [NT-1:0]             ThreadRspValid;
  logic [DW-1:0]             ThreadRspData;
  logic                      ErrUnexpRsp;
  logic                      ErrIllegalOp;

  int total = 0;
  int bad   = 0;

  gpc_4t_c2f_req_arb #(.NUM_THREADS(NT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .QClk                 (QClk),
    .RstQnnnL             (RstQnnnL),
    .ThreadReqValid       (ThreadReqValid),
    .ThreadReqOpcode      (ThreadReqOpcode),
    .ThreadReqAddress     (ThreadReqAddress),
    .ThreadReqData        (ThreadReqData),
    .ThreadReqReady       (ThreadReqReady),
    .C2F_ReqValidQ500H    (C2F_ReqValidQ500H),
    .C2F_ReqOpcodeQ500H   (C2F_ReqOpcodeQ500H),
    .C2F_ReqThreadIDQ500H (C2F_ReqThreadIDQ500H),
    .C2F_ReqAddressQ500H  (C2F_ReqAddressQ500H),
    .C2F_ReqDataQ500H     (C2F_ReqDataQ500H),
    .C2F_RspStall         (C2F_RspStall),
    .C2F_RspValidQ502H    (C2F_RspValidQ502H),
    .C2F_RspThreadIDQ502H (C2F_RspThreadIDQ502H),
    .C2F_RspDataQ502H     (C2F_RspDataQ502H),
    .ThreadRspValid       (ThreadRspValid),
    .ThreadRspData        (ThreadRspData),
    .ErrUnexpRsp          (ErrUnexpRsp),
    .ErrIllegalOp         (ErrIllegalOp)
  );

  always #5 QClk = ~QClk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge QClk);
    #1;
  endtask

  task automatic do_rst();
    RstQnnnL = 1'b0;
    tick();
    RstQnnnL = 1'b1;
  endtask

  task automatic chk_req(input string tag, input logic [1:0] tid, input logic [1:0] op,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
    chk({tag, "_vld"},  64'(C2F_ReqValidQ500H),    64'd1);
    chk({tag, "_tid"},  64'(C2F_ReqThreadIDQ500H), 64'(tid));
    chk({tag, "_op"},   64'(C2F_ReqOpcodeQ500H),   64'(op));
    chk({tag, "_addr"}, 64'(C2F_ReqAddressQ500H),  64'(addr));
    chk({tag, "_data"}, 64'(C2F_ReqDataQ500H),     64'(data));
  endtask

  task automatic strobe_all_writes();
    for (int t = 0; t < NT; t++) begin
      ThreadReqOpcode[t]  = 2'b01;
      ThreadReqAddress[t] = 32'h0000_1000 + 32'(t * 16);
      ThreadReqData[t]    = 32'hA5A5_0000 + 32'(t);
    end
    ThreadReqValid = 4'b1111;
    tick();
    ThreadReqValid = 4'b0000;
  endtask

  initial begin
    RstQnnnL             = 1'b0;
    ThreadReqValid       = '0;
    ThreadReqOpcode      = '0;
    ThreadReqAddress     = '0;
    ThreadReqData        = '0;
    C2F_RspStall         = 1'b0;
    C2F_RspValidQ502H    = 1'b0;
    C2F_RspThreadIDQ502H = '0;
    C2F_RspDataQ502H     = '0;
    tick();
    tick();
    RstQnnnL = 1'b1;

    // Reset state
    chk("rst_ready", 64'(ThreadReqReady),    64'hF);
    chk("rst_vld",   64'(C2F_ReqValidQ500H), 64'd0);
    chk("rst_rsp",   64'(ThreadRspValid),    64'd0);
    chk("rst_eu",    64'(ErrUnexpRsp),       64'd0);
    chk("rst_ei",    64'(ErrIllegalOp),      64'd0);

    // Thread 0 read round trip
    ThreadReqOpcode[0]  = 2'b00;
    ThreadReqAddress[0] = 32'h0040_0100;
    ThreadReqData[0]    = 32'h0;
    ThreadReqValid      = 4'b0001;
    tick();
    ThreadReqValid = 4'b0000;
    chk("rd_vld_early", 64'(C2F_ReqValidQ500H), 64'd0);
    chk("rd_ready_pend", 64'(ThreadReqReady), 64'hE);
    tick();
    chk_req("rd_issue", 2'd0, 2'b00, 32'h0040_0100, 32'h0);
    tick();
    chk("rd_vld_drop", 64'(C2F_ReqValidQ500H), 64'd0);
    chk("rd_ready_wait", 64'(ThreadReqReady), 64'hE);
    tick();
    chk("rd_ready_wait2", 64'(ThreadReqReady), 64'hE);
    C2F_RspValidQ502H    = 1'b1;
    C2F_RspThreadIDQ502H = 2'd0;
    C2F_RspDataQ502H     = 32'hDEAD_BEEF;
    tick();
    C2F_RspValidQ502H = 1'b0;
    chk("rd_rsp_vld",   64'(ThreadRspValid), 64'h1);
    chk("rd_rsp_data",  64'(ThreadRspData),  64'hDEAD_BEEF);
    chk("rd_rsp_eu",    64'(ErrUnexpRsp),    64'd0);
    chk("rd_ready_back", 64'(ThreadReqReady), 64'hF);
    tick();
    chk("rd_rsp_pulse", 64'(ThreadRspValid), 64'h0);

    // Four simultaneous writes issue 0,1,2,3 after reset
    do_rst();
    strobe_all_writes();
    for (int t = 0; t < NT; t++) begin
      tick();
      chk_req($sformatf("rr%0d", t), 2'(t), 2'b01, 32'h0000_1000 + 32'(t * 16),
              32'hA5A5_0000 + 32'(t));
    end
    tick();
    chk("rr_idle_vld", 64'(C2F_ReqValidQ500H), 64'd0);
    chk("rr_ready",    64'(ThreadReqReady),    64'hF);

    // Stall while thread 2 is on the outputs
    do_rst();
    strobe_all_writes();
    tick();
    tick();
    tick();
    chk_req("st_pre", 2'd2, 2'b01, 32'h0000_1020, 32'hA5A5_0002);
    C2F_RspStall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_req($sformatf("st_hold%0d", c), 2'd2, 2'b01, 32'h0000_1020, 32'hA5A5_0002);
      chk($sformatf("st_rdy%0d", c), 64'(ThreadReqReady), 64'h7);
    end
    C2F_RspStall = 1'b0;
    tick();
    chk_req("st_t3", 2'd3, 2'b01, 32'h0000_1030, 32'hA5A5_0003);
    tick();
    chk("st_idle", 64'(C2F_ReqValidQ500H), 64'd0);

    // Unexpected response for idle thread 1
    C2F_RspValidQ502H    = 1'b1;
    C2F_RspThreadIDQ502H = 2'd1;
    C2F_RspDataQ502H     = 32'h1234_5678;
    tick();
    C2F_RspValidQ502H = 1'b0;
    chk("ux_rsp", 64'(ThreadRspValid), 64'h0);
    chk("ux_err", 64'(ErrUnexpRsp),    64'd1);
    tick();
    chk("ux_err_pulse", 64'(ErrUnexpRsp), 64'd0);

    // Thread 3 read outstanding, then reset
    ThreadReqOpcode[3]  = 2'b00;
    ThreadReqAddress[3] = 32'h0000_3300;
    ThreadReqValid      = 4'b1000;
    tick();
    ThreadReqValid = 4'b0000;
    tick();
    chk_req("r3_issue", 2'd3, 2'b00, 32'h0000_3300, 32'hA5A5_0003);
    tick();
    chk("r3_wait", 64'(ThreadReqReady), 64'h7);
    do_rst();
    chk("r3_rst_ready", 64'(ThreadReqReady),       64'hF);
    chk("r3_rst_vld",   64'(C2F_ReqValidQ500H),    64'd0);
    chk("r3_rst_op",    64'(C2F_ReqOpcodeQ500H),   64'd0);
    chk("r3_rst_tid",   64'(C2F_ReqThreadIDQ500H), 64'd0);
    chk("r3_rst_addr",  64'(C2F_ReqAddressQ500H),  64'd0);
    chk("r3_rst_data",  64'(C2F_ReqDataQ500H),     64'd0);
    C2F_RspValidQ502H    = 1'b1;
    C2F_RspThreadIDQ502H = 2'd3;
    tick();
    C2F_RspValidQ502H = 1'b0;
    chk("r3_late_err", 64'(ErrUnexpRsp),    64'd1);
    chk("r3_late_rsp", 64'(ThreadRspValid), 64'h0);

    // Illegal opcode on thread 1
    ThreadReqOpcode[1]  = 2'b11;
    ThreadReqAddress[1] = 32'h0000_2222;
    ThreadReqData[1]    = 32'h0000_3333;
    ThreadReqValid      = 4'b0010;
    tick();
    ThreadReqValid = 4'b0000;
    chk("il_ei_early", 64'(ErrIllegalOp), 64'd0);
    tick();
    chk_req("il_issue", 2'd1, 2'b11, 32'h0000_2222, 32'h0000_3333);
    chk("il_err",   64'(ErrIllegalOp),   64'd1);
    chk("il_ready", 64'(ThreadReqReady), 64'hF);
    tick();
    chk("il_err_pulse", 64'(ErrIllegalOp),   64'd0);
    chk("il_ready2",    64'(ThreadReqReady), 64'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpc_4t_c2f_req_arb.md
Name: gpc_4t_c2f_req_arb

Overview:
- Per-core arbiter between the 4 hardware threads of gpc_4t and the single core-to-fabric (C2F) request port.
- Buffers one request per thread and grants threads round-robin onto the registered C2F request outputs.
- Holds the outputs while the fabric asserts stall, and tracks one outstanding read per thread.
- Routes C2F responses back to the issuing thread by ThreadID. Sits between the gpc_4t memory stage and the C2F fabric ports.

Parameters:
- NUM_THREADS, 4, number of requesters; ThreadID width is fixed at 2 bits.
- ADDR_W, 32, request address width.
- DATA_W, 32, request and response data width.

Ports:
- QClk  in  1  core clock; all logic is on the rising edge.
- RstQnnnL  in  1  synchronous, active-low reset; sampled on the QClk rising edge.
- ThreadReqValid  in  4  per-thread request strobe.
- ThreadReqOpcode  in  4x2  per-thread opcode: 2'b00 = read, 2'b01 = write, others illegal.
- ThreadReqAddress  in  4xADDR_W  per-thread address.
- ThreadReqData  in  4xDATA_W  per-thread write data.
- ThreadReqReady  out  4  thread may present a request this cycle.
- C2F_ReqValidQ500H  out  1  request valid to fabric.
- C2F_ReqOpcodeQ500H  out  2  request opcode.
- C2F_ReqThreadIDQ500H  out  2  issuing thread.
- C2F_ReqAddressQ500H  out  ADDR_W  request address.
- C2F_ReqDataQ500H  out  DATA_W  request data.
- C2F_RspStall  in  1  fabric cannot accept; outputs must hold.
- C2F_RspValidQ502H  in  1  response valid.
- C2F_RspThreadIDQ502H  in  2  response target thread.
- C2F_RspDataQ502H  in  DATA_W  read data.
- ThreadRspValid  out  4  one-hot response pulse to a thread.
- ThreadRspData  out  DATA_W  response data, shared by all threads.
- ErrUnexpRsp  out  1  one-cycle pulse: response arrived for a thread not waiting on a read.
- ErrIllegalOp  out  1  one-cycle pulse: illegal opcode accepted.

Behaviour:
- Reset (RstQnnnL=0 at a clock edge):
  - All outputs go to 0, except ThreadReqReady, which goes to 4'b1111.
  - All thread states go to IDLE; the RR pointer goes to 3, so thread 0 has first priority.
  - Reset mid-operation discards all buffered and outstanding state; late responses arriving after reset raise ErrUnexpRsp.
- Per-thread FSM, states IDLE / PEND / WAIT_RSP:
  - ThreadReqReady[t] = (state == IDLE), driven from registered state.
  - IDLE -> PEND: on ThreadReqValid[t] & ThreadReqReady[t]. The opcode, address and data are captured into that thread's buffer at the same edge.
  - ThreadReqValid while not ready is ignored and never captured.
  - PEND -> granted: a granted write or illegal-opcode request goes to IDLE; a granted read goes to WAIT_RSP.
  - WAIT_RSP -> IDLE: on C2F_RspValidQ502H with C2F_RspThreadIDQ502H == t.
- Issue slot:
  - The slot is free when C2F_ReqValidQ500H=0 or C2F_RspStall=0.
  - When the slot is free and at least one thread is PEND, grant the first PEND thread searching from pointer+1 modulo 4.
  - At the grant edge: load the output registers from that thread's buffer, set the pointer to the granted thread, and advance the thread's FSM.
  - When the slot is free and no thread is PEND, C2F_ReqValidQ500H goes to 0 at the next edge.
  - When C2F_RspStall=1 and valid=1, all C2F_Req outputs hold their values and no grant occurs.
- Latency: capture at edge N, earliest output valid after edge N+1, i.e. one cycle in PEND minimum. No thread can be accepted and issued in the same cycle.
- Fairness: with all 4 threads PEND continuously, grants rotate 0,1,2,3,0,... and each thread waits at most 3 grants.
- Responses:
  - ThreadRspValid[id] and ThreadRspData are registered, valid one cycle after the C2F response, and last one cycle.
  - This happens only if thread id is in WAIT_RSP. Otherwise the response is dropped and ErrUnexpRsp pulses one cycle later.
- Same-cycle response and grant:
  - A thread leaving WAIT_RSP reaches IDLE at that edge and can be captured at the next edge.
  - A response cannot retire a read being granted in the same cycle, because that thread is still in PEND.
- Illegal opcode: the request is forwarded unchanged, treated as a write (no outstanding tracking), and ErrIllegalOp pulses one cycle after the grant edge.

Test Plan:
- Reset, then thread 0 read to address 0x0040_0100:
  - C2F_ReqValidQ500H is seen 2 cycles after the strobe, with opcode 00 and ThreadID 0.
  - ThreadReqReady[0] is 0 until a response with ThreadID 0 and data 0xDEAD_BEEF; then ThreadRspValid = 4'b0001 and ThreadRspData = 0xDEAD_BEEF one cycle later.
  - ThreadReqReady[0] returns to 1.
- All 4 threads strobe writes in the same cycle -> issue order is ThreadID 0,1,2,3 on 4 consecutive cycles, each carrying its own address and data.
- Hold C2F_RspStall=1 for 5 cycles while thread 2's write is on the outputs -> all C2F_Req outputs are unchanged for 5 cycles, there is no new grant, and thread 3 (PEND) issues the cycle after the stall drops.
- Response with ThreadID 1 while thread 1 is IDLE -> ThreadRspValid stays 0 and ErrUnexpRsp is a single pulse.
- Thread 3 read outstanding, then RstQnnnL=0 for 1 cycle -> ThreadReqReady = 4'b1111 and outputs are 0; a subsequent response for thread 3 raises ErrUnexpRsp.
- Thread 1 opcode 2'b11 -> the request is forwarded with opcode 11, ErrIllegalOp pulses, and ThreadReqReady[1] returns to 1 with no response required.
